// File: rtl/array_heap.sv
// Heap of fixed-capacity arrays driven through a req/ready/done handshake.
// Each accepted action produces one registered result; a clear sweep resets array metadata.
module array_heap #(
    parameter int WIDTH  = 12,
    parameter int ARRAYS = 8,
    parameter int SIZE   = 8,
    parameter int AW     = $clog2(ARRAYS),
    parameter int IW     = $clog2(SIZE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic [3:0]       action,
    input  logic [AW-1:0]    array,
    input  logic [IW-1:0]    index,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result
);
    localparam int CW = AW + 1;

    localparam logic [3:0] ACT_NOP   = 4'd0;
    localparam logic [3:0] ACT_RESET = 4'd1;
    localparam logic [3:0] ACT_ALLOC = 4'd2;
    localparam logic [3:0] ACT_FREE  = 4'd3;
    localparam logic [3:0] ACT_WRITE = 4'd4;
    localparam logic [3:0] ACT_READ  = 4'd5;
    localparam logic [3:0] ACT_PUSH  = 4'd6;
    localparam logic [3:0] ACT_POP   = 4'd7;
    localparam logic [3:0] ACT_SIZE  = 4'd8;

    typedef enum logic [1:0] {CLEAR, IDLE, BUSY} state_t;
    state_t state, state_next;

    logic [AW-1:0]    ptr;
    logic             from_action;
    logic [3:0]       act_q;
    logic [AW-1:0]    arr_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] data_q;

    logic [WIDTH-1:0] mem   [ARRAYS][SIZE];
    logic [IW:0]      sizes [ARRAYS];
    logic [AW-1:0]    stack [ARRAYS];
    logic [ARRAYS-1:0] alloc;
    logic [CW-1:0]    alloc_cnt, freed_top;

    logic             exec_err;
    logic [WIDTH-1:0] exec_res;
    logic [AW-1:0]    alloc_id, top_idx;
    logic [IW:0]      cur_size, size_m1, size_p1, idx_p1;
    logic             is_alloc, last_ptr;

    assign ready    = (state == IDLE);
    assign cur_size = sizes[arr_q];
    assign size_m1  = cur_size - 1'b1;
    assign size_p1  = cur_size + 1'b1;
    assign idx_p1   = {1'b0, idx_q} + 1'b1;
    assign is_alloc = alloc[arr_q];
    assign top_idx  = AW'(freed_top - 1'b1);
    assign last_ptr = (ptr == AW'(ARRAYS - 1));

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (last_ptr) state_next = IDLE;
            IDLE:    if (req) state_next = BUSY;
            BUSY:    state_next = (act_q == ACT_RESET) ? CLEAR : IDLE;
            default: state_next = CLEAR;
        endcase
    end

    // Validity check and result of the latched action; on error result stays 0.
    always_comb begin
        exec_err = 1'b0;
        exec_res = '0;
        alloc_id = '0;
        case (act_q)
            ACT_NOP, ACT_RESET: ;
            ACT_ALLOC: begin
                if (freed_top != '0)                alloc_id = stack[top_idx];
                else if (alloc_cnt < CW'(ARRAYS))   alloc_id = alloc_cnt[AW-1:0];
                else                                exec_err = 1'b1;
                exec_res = WIDTH'(alloc_id);
            end
            ACT_FREE: begin
                exec_err = !is_alloc;
                exec_res = WIDTH'(arr_q);
            end
            ACT_WRITE: begin
                exec_err = !is_alloc || !({1'b0, idx_q} < (IW+1)'(SIZE));
                exec_res = data_q;
            end
            ACT_READ: begin
                exec_err = !is_alloc || !({1'b0, idx_q} < cur_size);
                exec_res = mem[arr_q][idx_q];
            end
            ACT_PUSH: begin
                exec_err = !is_alloc || !(cur_size < (IW+1)'(SIZE));
                exec_res = WIDTH'(size_p1);
            end
            ACT_POP: begin
                exec_err = !is_alloc || (cur_size == '0);
                exec_res = mem[arr_q][size_m1[IW-1:0]];
            end
            ACT_SIZE: begin
                exec_err = !is_alloc;
                exec_res = WIDTH'(cur_size);
            end
            default: exec_err = 1'b1;
        endcase
        if (exec_err) exec_res = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= CLEAR;
            ptr         <= '0;
            alloc_cnt   <= '0;
            freed_top   <= '0;
            from_action <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            result      <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                CLEAR: begin
                    sizes[ptr] <= '0;
                    alloc[ptr] <= 1'b0;
                    ptr        <= last_ptr ? '0 : ptr + 1'b1;
                    if (last_ptr && from_action) begin
                        done        <= 1'b1;
                        error       <= 1'b0;
                        result      <= '0;
                        from_action <= 1'b0;
                    end
                end
                IDLE: if (req) begin
                    act_q  <= action;
                    arr_q  <= array;
                    idx_q  <= index;
                    data_q <= data;
                end
                BUSY: begin
                    if (act_q == ACT_RESET) begin
                        // Completion is reported when the sweep finishes.
                        ptr         <= '0;
                        alloc_cnt   <= '0;
                        freed_top   <= '0;
                        from_action <= 1'b1;
                    end else begin
                        done   <= 1'b1;
                        error  <= exec_err;
                        result <= exec_res;
                    end
                    if (!exec_err) begin
                        case (act_q)
                            ACT_ALLOC: begin
                                alloc[alloc_id] <= 1'b1;
                                sizes[alloc_id] <= '0;
                                if (freed_top != '0) freed_top <= freed_top - 1'b1;
                                else                 alloc_cnt <= alloc_cnt + 1'b1;
                            end
                            ACT_FREE: begin
                                alloc[arr_q]                <= 1'b0;
                                sizes[arr_q]                <= '0;
                                stack[freed_top[AW-1:0]]    <= arr_q;
                                freed_top                   <= freed_top + 1'b1;
                            end
                            ACT_WRITE: begin
                                mem[arr_q][idx_q] <= data_q;
                                if (idx_p1 > cur_size) sizes[arr_q] <= idx_p1;
                            end
                            ACT_PUSH: begin
                                mem[arr_q][cur_size[IW-1:0]] <= data_q;
                                sizes[arr_q]                 <= size_p1;
                            end
                            ACT_POP: sizes[arr_q] <= size_m1;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_array_heap.sv
// Directed bench for array_heap; expected {error,result} pairs are queued per action
// and checked by a monitor whenever done pulses.
module tb_array_heap;
    localparam int WIDTH = 12, ARRAYS = 8, SIZE = 8, AW = 3, IW = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req = 1'b0;
    logic [3:0]       action = '0;
    logic [AW-1:0]    array = '0;
    logic [IW-1:0]    index = '0;
    logic [WIDTH-1:0] data = '0;
    logic             ready, done, error;
    logic [WIDTH-1:0] result;

    int asserts = 0;
    int fails   = 0;
    logic [WIDTH:0] sb[$];

    array_heap #(.WIDTH(WIDTH), .ARRAYS(ARRAYS), .SIZE(SIZE)) dut (
        .clock(clock), .reset(reset), .req(req), .action(action), .array(array),
        .index(index), .data(data), .ready(ready), .done(done), .error(error),
        .result(result)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        asserts++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [WIDTH:0] e;
                e = sb.pop_front();
                chk("done_error", 32'(error), 32'(e[WIDTH]));
                chk("done_result", 32'(result), 32'(e[WIDTH-1:0]));
            end
        end
    end

    // Issue one action from a negedge and wait for its done.
    task automatic act(input logic [3:0] a, input int arr, input int idx, input int d,
                       input logic exp_err, input int exp_res);
        bit seen;
        for (int i = 0; i < 30 && ready !== 1'b1; i++) @(negedge clock);
        if (ready !== 1'b1) chk("ready_timeout", 32'(ready), 32'd1);
        action = a; array = AW'(arr); index = IW'(idx); data = WIDTH'(d); req = 1'b1;
        sb.push_back({exp_err, WIDTH'(exp_res)});
        @(posedge clock);
        #1 req = 1'b0;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1;
        end
        if (!seen) chk("done_timeout", 32'(seen), 32'd1);
    endtask

    // Called at the negedge just after reset is released.
    task automatic sweep_check(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clock);
            #1 chk({tag, "_ready_low"}, 32'(ready), 32'd0);
        end
        @(negedge clock);
        #1 chk({tag, "_ready_high"}, 32'(ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        reset = 1'b0;
        sweep_check("pin_sweep");
        @(negedge clock);

        // Allocation with reuse of freed ids
        act(4'd2, 0, 0, 0, 0, 0);
        act(4'd2, 0, 0, 0, 0, 1);
        act(4'd2, 0, 0, 0, 0, 2);
        act(4'd3, 1, 0, 0, 0, 1);
        act(4'd2, 0, 0, 0, 0, 1);
        act(4'd2, 0, 0, 0, 0, 3);

        // RESET action, then exhaust the heap
        act(4'd1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) act(4'd2, 0, 0, 0, 0, i);
        act(4'd2, 0, 0, 0, 1, 0);

        // Element access on array 0
        act(4'd4, 0, 4, 5, 0, 5);
        act(4'd8, 0, 0, 0, 0, 5);
        act(4'd5, 0, 4, 0, 0, 5);
        act(4'd5, 0, 6, 0, 1, 0);
        act(4'd6, 0, 0, 7, 0, 6);
        act(4'd7, 0, 0, 0, 0, 7);
        act(4'd7, 0, 0, 0, 0, 5);
        act(4'd8, 0, 0, 0, 0, 4);

        // Unallocated / empty / full errors
        act(4'd3, 2, 0, 0, 0, 2);
        act(4'd3, 2, 0, 0, 1, 0);
        act(4'd5, 2, 0, 0, 1, 0);
        act(4'd7, 2, 0, 0, 1, 0);
        act(4'd7, 3, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) act(4'd6, 1, 0, 16 + i, 0, i + 1);
        act(4'd6, 1, 0, 99, 1, 0);
        act(4'd5, 1, 7, 0, 0, 23);
        act(4'd8, 1, 0, 0, 0, 8);
        act(4'd0, 0, 0, 0, 0, 0);
        act(4'd9, 0, 0, 0, 1, 0);
        act(4'd15, 0, 0, 0, 1, 0);
        act(4'd2, 0, 0, 0, 0, 2);
        act(4'd2, 0, 0, 0, 1, 0);

        // RESET action clears the heap
        act(4'd1, 0, 0, 0, 0, 0);
        act(4'd8, 1, 0, 0, 1, 0);
        act(4'd2, 0, 0, 0, 0, 0);
        act(4'd2, 0, 0, 0, 0, 1);

        // Reset pin while BUSY: aborted action never reports
        action = 4'd2; req = 1'b1;
        @(posedge clock);
        #1 req = 1'b0; reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("busy_rst_done", 32'(done), 32'd0);
        chk("busy_rst_ready", 32'(ready), 32'd0);
        reset = 1'b0;
        sweep_check("busy_sweep");
        @(negedge clock);
        act(4'd2, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/array_heap.md
Name: array_heap

Overview:
- Parametrised heap of fixed-capacity arrays for the FPGA test-program engine; successor to the single-action reset-only memory.
- Supports allocate, free with reuse of freed arrays, indexed read/write, push/pop and size query.
- The program sequencer drives it via a req/ready/done handshake and receives one registered result per accepted action.

Parameters:
- WIDTH, 12, data word width in bits; must be >= AW and >= IW+1.
- ARRAYS, 8, number of arrays in the heap.
- SIZE, 8, maximum elements per array.
- AW, $clog2(ARRAYS), array-id width.
- IW, $clog2(SIZE), element-index width.

Ports:
- clock  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  action request; sampled only when ready=1.
- action  input  4  0 NOP, 1 RESET, 2 ALLOC, 3 FREE, 4 WRITE, 5 READ, 6 PUSH, 7 POP, 8 SIZE.
- array  input  AW  target array id.
- index  input  IW  element index (WRITE/READ).
- data  input  WIDTH  write/push data.
- ready  output  1  high when idle and able to accept req.
- done  output  1  one-cycle pulse; result/error valid.
- error  output  1  action failed; valid with done.
- result  output  WIDTH  action result; valid with done, held until next done.

Behaviour:
- State: mem[ARRAYS][SIZE] words; size[ARRAYS] (IW+1 bits); alloc[ARRAYS] bits; allocatedArrays counter (0..ARRAYS); freed stack[ARRAYS] of ids with freedTop (0..ARRAYS).
- FSM states: CLEAR, IDLE, BUSY.
- reset=1: state <= CLEAR, sweep ptr <= 0, allocatedArrays <= 0, freedTop <= 0, ready=0, done=0, error=0, result=0. mem contents are not cleared.
- CLEAR: one array per cycle: size[ptr] <= 0, alloc[ptr] <= 0, ptr++.
  - After ptr=ARRAYS-1 is cleared → IDLE; ready rises next cycle.
  - done pulses at end of sweep only if the sweep was started by a RESET action, not by the reset pin.
- IDLE: ready=1. req=1 latches action/array/index/data, ready <= 0, → BUSY. NOP completes as a normal action.
- BUSY (one cycle): execute, register result/error, done=1, → IDLE. Done appears the cycle after acceptance; ready returns with done.
- Back-to-back rate: one action per 2 cycles.
- Action RESET: → CLEAR (ptr=0) instead of IDLE, allocatedArrays=0, freedTop=0; done deferred to sweep end.
- ALLOC:
  - If freedTop>0: id = stack[freedTop-1], freedTop--.
  - Else if allocatedArrays<ARRAYS: id = allocatedArrays, allocatedArrays++.
  - Else error=1, result=0.
  - On success: alloc[id]=1, size[id]=0, result=id.
- FREE: requires alloc[array]=1, else error. On success: alloc=0, size=0, push array onto stack, result=array.
- WRITE: requires alloc[array]=1 and index<SIZE. On success: mem=data, size[array] = max(size, index+1), result=data.
- READ: requires alloc[array]=1 and index<size[array], else error; result=mem[array][index].
- PUSH: requires alloc[array]=1 and size<SIZE. On success: mem[array][size]=data, size++, result=new size.
- POP: requires alloc[array]=1 and size>0. On success: size--, result=mem[array][size-1 before decrement].
- SIZE: requires alloc[array]=1; result=size[array], zero-extended.
- Codes 9-15: error=1, no state change.
- On any error: no state change, result=0.
- reset during BUSY or CLEAR: abort immediately, no done; restart clear sweep.
- req while ready=0 is ignored (not queued).

Test Plan:
- reset for 2 cycles, then release → ready=0 for exactly 8 cycles, ready=1 on cycle 9, no done pulse.
- ALLOC x3 → results 0, 1, 2; FREE 1, then ALLOC → result 1 (reused); next ALLOC → 3.
- ALLOC 8 times → ids 0..7; 9th ALLOC → done with error=1, result=0.
- On array 0: WRITE idx 4 data 5 → SIZE=5; READ idx 4 → 5; READ idx 6 → error; PUSH 7 → result 6; POP → 7; POP → 5.
- Array 2 unallocated: FREE 2 / READ 2 / POP 2 → error each. POP on empty allocated array → error. PUSH onto full array (size 8) → error.
- RESET action after allocations: done after sweep end; then ALLOC → 0. Assert reset pin while BUSY → no done pulse, sweep restarts.
